// File: rtl/dtw_arb_pkg.sv
// Shared types and sizing helpers for the DTW result arbiter.
// ID_W is the width of the core-ID tag prepended to every FIFO word.
package dtw_arb_pkg;

    localparam int ID_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_PUSH = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    function automatic int data_w(input int tdata_w);
        return tdata_w - ID_W;
    endfunction

    // Pointer/index width; a single-core build still needs one bit.
    function automatic int ptr_w(input int num_cores);
        return (num_cores > 1) ? $clog2(num_cores) : 1;
    endfunction

endpackage

// File: rtl/dtw_result_arbiter_if.sv
// Batch control, per-core request and FIFO write-side signals of the result arbiter.
// core_enable exists only when DTW_ARB_CORE_MASK_EN is defined.
interface dtw_result_arbiter_if #(
    parameter int NUM_CORES            = 4,
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int CNT_W                = 16
);
    localparam int DATA_W = dtw_arb_pkg::data_w(C_M_AXIS_TDATA_WIDTH);

    logic                            start;
    logic [CNT_W-1:0]                cfg_total;
    logic                            busy;
    logic                            done;
    logic [NUM_CORES-1:0]            res_valid;
    logic [NUM_CORES*DATA_W-1:0]     res_data;
    logic [NUM_CORES-1:0]            res_ack;
    logic                            dtw_fifo_wren;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] dtw_fifo_din;
    logic                            dtw_fifo_full;
`ifdef DTW_ARB_CORE_MASK_EN
    logic [NUM_CORES-1:0]            core_enable;
`endif

    modport master (
        input  start,
        input  cfg_total,
        input  res_valid,
        input  res_data,
        input  dtw_fifo_full,
`ifdef DTW_ARB_CORE_MASK_EN
        input  core_enable,
`endif
        output busy,
        output done,
        output res_ack,
        output dtw_fifo_wren,
        output dtw_fifo_din
    );

    modport slave (
        output start,
        output cfg_total,
        output res_valid,
        output res_data,
        output dtw_fifo_full,
`ifdef DTW_ARB_CORE_MASK_EN
        output core_enable,
`endif
        input  busy,
        input  done,
        input  res_ack,
        input  dtw_fifo_wren,
        input  dtw_fifo_din
    );

endinterface

// File: rtl/dtw_rr_picker.sv
// Combinational round-robin priority encoder: first set req bit at or above
// rr_ptr, wrapping from NUM_CORES-1 back to 0.
module dtw_rr_picker
    import dtw_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int PTR_W     = ptr_w(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic                 any,
    output logic [PTR_W-1:0]     winner
);

    int               pos;
    logic [PTR_W-1:0] cand;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        pos    = 0;
        cand   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= NUM_CORES) begin
                pos = pos - NUM_CORES;
            end
            cand = PTR_W'(pos);
            if (!any && req[cand]) begin
                any    = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/dtw_result_arbiter.sv
// Batch controller sharing one result-FIFO write port among NUM_CORES DTW cores.
// Define DTW_ARB_CORE_MASK_EN to add the per-core core_enable eligibility mask.
//
//   state | meaning
//   IDLE  | waiting for start; busy low
//   ARB   | round-robin pick among eligible requests, latch word, pulse res_ack
//   PUSH  | present latched word; write when FIFO not full, count it
//   DONE  | batch complete; done pulses and busy drops on exit
module dtw_result_arbiter
    import dtw_arb_pkg::*;
#(
    parameter int NUM_CORES            = 4,
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int CNT_W                = 16
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    dtw_result_arbiter_if.master  bus
);

    localparam int DATA_W = data_w(C_M_AXIS_TDATA_WIDTH);
    localparam int PTR_W  = ptr_w(NUM_CORES);

    arb_state_t                      state_q, state_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic [NUM_CORES-1:0]            ack_q, ack_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] din_q, din_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [CNT_W-1:0]                total_q, total_d;
    logic [PTR_W-1:0]                rr_q, rr_d;

    logic [NUM_CORES-1:0]            eligible;
    logic                            pick_any;
    logic [PTR_W-1:0]                pick_win;
    logic [CNT_W-1:0]                cnt_inc;
    logic                            wren;
    logic [DATA_W-1:0]               payload [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_payload
        assign payload[g] = bus.res_data[g*DATA_W +: DATA_W];
    end

`ifdef DTW_ARB_CORE_MASK_EN
    assign eligible = bus.res_valid & bus.core_enable;
`else
    assign eligible = bus.res_valid;
`endif

    dtw_rr_picker #(
        .NUM_CORES (NUM_CORES),
        .PTR_W     (PTR_W)
    ) u_picker (
        .req    (eligible),
        .rr_ptr (rr_q),
        .any    (pick_any),
        .winner (pick_win)
    );

    assign wren    = (state_q == ST_PUSH) && !bus.dtw_fifo_full;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ack_d   = '0;
        din_d   = din_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        rr_d    = rr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    total_d = bus.cfg_total;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (bus.cfg_total == '0) ? ST_DONE : ST_ARB;
                end
            end
            ST_ARB: begin
                if (pick_any) begin
                    din_d           = {ID_W'(pick_win), payload[pick_win]};
                    ack_d[pick_win] = 1'b1;
                    rr_d            = (pick_win == PTR_W'(NUM_CORES - 1)) ? '0
                                                                          : pick_win + PTR_W'(1);
                    state_d         = ST_PUSH;
                end
            end
            ST_PUSH: begin
                // Compare on every write so the count can never pass the total.
                if (wren) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == total_q) ? ST_DONE : ST_ARB;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= '0;
            din_q   <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.res_ack       = ack_q;
    assign bus.dtw_fifo_wren = wren;
    assign bus.dtw_fifo_din  = din_q;

endmodule

// File: tb/tb_dtw_result_arbiter.sv
// Directed bench for dtw_result_arbiter: behavioural cores that drop/advance
// their request on the edge after seeing res_ack, plus logs of FIFO writes.
module tb_dtw_result_arbiter;

    localparam int NC = 4;
    localparam int TW = 32;
    localparam int CW = 16;
    localparam int DW = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dtw_result_arbiter_if #(.NUM_CORES(NC), .C_M_AXIS_TDATA_WIDTH(TW), .CNT_W(CW)) bus ();

    dtw_result_arbiter #(.NUM_CORES(NC), .C_M_AXIS_TDATA_WIDTH(TW), .CNT_W(CW)) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .bus            (bus.master)
    );

    int             n_chk  = 0;
    int             n_fail = 0;
    int             core_left [NC];
    logic [DW-1:0]  core_pay  [NC];
    logic [NC-1:0]  ack_prev;
    logic [31:0]    wr_log [$];
    int             grant_log [$];
    int             done_cnt;
    int             ack_cnt;

    logic [31:0] exp_rr [8] = '{32'h000000B0, 32'h010000C0, 32'h020000D0, 32'h030000E0,
                                32'h000000B1, 32'h010000C1, 32'h020000D1, 32'h030000E1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cores();
        for (int i = 0; i < NC; i++) begin
            bus.res_valid[i]             = (core_left[i] != 0);
            bus.res_data[i*DW +: DW]     = core_pay[i];
        end
    endtask

    task automatic sample();
        if (bus.res_ack != '0) begin
            ack_cnt++;
            for (int i = 0; i < NC; i++) if (bus.res_ack[i]) grant_log.push_back(i);
            chk("ack_onehot", 32'($onehot(bus.res_ack)), 32'd1);
            chk("ack_one_cycle", 32'(ack_prev), 32'd0);
        end
        if (bus.dtw_fifo_wren) wr_log.push_back(bus.dtw_fifo_din);
        if (bus.done) begin
            done_cnt++;
            chk("busy_low_at_done", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (ack_prev[i] && core_left[i] > 0) begin
                core_left[i]--;
                core_pay[i] = core_pay[i] + 1'b1;
            end
        end
        drive_cores();
        #1;
        sample();
        ack_prev = bus.res_ack;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        grant_log.delete();
        done_cnt = 0;
        ack_cnt  = 0;
    endtask

    task automatic start_batch(input logic [CW-1:0] total);
        bus.cfg_total = total;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            step();
            k++;
        end
        chk("done_seen", 32'(done_cnt), 32'd1);
    endtask

    task automatic apply_reset();
        #1;
        rst_n    = 1'b0;
        ack_prev = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
    endtask

    initial begin
        int k;
        bus.start         = 1'b0;
        bus.cfg_total     = '0;
        bus.dtw_fifo_full = 1'b0;
`ifdef DTW_ARB_CORE_MASK_EN
        bus.core_enable   = '1;
`endif
        for (int i = 0; i < NC; i++) begin
            core_left[i] = 0;
            core_pay[i]  = '0;
        end
        drive_cores();
        ack_prev = '0;
        clear_logs();

        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ack", 32'(bus.res_ack), 32'd0);
        chk("rst_wren", 32'(bus.dtw_fifo_wren), 32'd0);
        chk("rst_din", bus.dtw_fifo_din, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        step();

        // Single core, three results
        core_left[2] = 3;
        core_pay[2]  = 24'hA1;
        clear_logs();
        drive_cores();
        start_batch(16'd3);
        chk("t1_busy_after_start", 32'(bus.busy), 32'd1);
        run_to_done(40);
        chk("t1_nwrites", 32'(wr_log.size()), 32'd3);
        chk("t1_word0", wr_log[0], 32'h020000A1);
        chk("t1_word1", wr_log[1], 32'h020000A2);
        chk("t1_word2", wr_log[2], 32'h020000A3);
        step(); step(); step();
        chk("t1_done_once", 32'(done_cnt), 32'd1);
        chk("t1_busy_idle", 32'(bus.busy), 32'd0);

        // All cores valid: strict round-robin from pointer 0
        apply_reset();
        for (int i = 0; i < NC; i++) begin
            core_left[i] = 2;
            core_pay[i]  = 24'hB0 + 24'(16 * i);
        end
        clear_logs();
        drive_cores();
        start_batch(16'd8);
        run_to_done(60);
        chk("t2_ngrants", 32'(grant_log.size()), 32'd8);
        chk("t2_nwrites", 32'(wr_log.size()), 32'd8);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("t2_grant%0d", j), 32'(grant_log[j]), 32'(j % 4));
            chk($sformatf("t2_word%0d", j), wr_log[j], exp_rr[j]);
        end
        step(); step();

        // FIFO full for five PUSH cycles
        core_left[1] = 2;
        core_pay[1]  = 24'h55;
        bus.dtw_fifo_full = 1'b1;
        clear_logs();
        drive_cores();
        start_batch(16'd2);
        k = 0;
        while (ack_cnt == 0 && k < 20) begin
            step();
            k++;
        end
        chk("t3_ack_seen", 32'(ack_cnt), 32'd1);
        chk("t3_wren_full0", 32'(bus.dtw_fifo_wren), 32'd0);
        chk("t3_din_full0", bus.dtw_fifo_din, 32'h01000055);
        for (int j = 1; j < 5; j++) begin
            step();
            chk($sformatf("t3_wren_full%0d", j), 32'(bus.dtw_fifo_wren), 32'd0);
            chk($sformatf("t3_din_full%0d", j), bus.dtw_fifo_din, 32'h01000055);
        end
        chk("t3_no_extra_ack", 32'(ack_cnt), 32'd1);
        bus.dtw_fifo_full = 1'b0;
        #1;
        chk("t3_wren_on_release", 32'(bus.dtw_fifo_wren), 32'd1);
        sample();
        run_to_done(30);
        chk("t3_nwrites", 32'(wr_log.size()), 32'd2);
        chk("t3_word0", wr_log[0], 32'h01000055);
        chk("t3_word1", wr_log[1], 32'h01000056);
        chk("t3_nacks", 32'(ack_cnt), 32'd2);
        step(); step();

        // Zero-length batch
        core_left[0] = 1;
        core_pay[0]  = 24'h99;
        clear_logs();
        drive_cores();
        start_batch(16'd0);
        chk("t4_done_c1", 32'(bus.done), 32'd0);
        chk("t4_busy_c1", 32'(bus.busy), 32'd1);
        step();
        chk("t4_done_c2", 32'(bus.done), 32'd1);
        chk("t4_busy_c2", 32'(bus.busy), 32'd0);
        step();
        chk("t4_done_c3", 32'(bus.done), 32'd0);
        chk("t4_no_ack", 32'(ack_cnt), 32'd0);
        chk("t4_no_wren", 32'(wr_log.size()), 32'd0);
        core_left[0] = 0;
        drive_cores();
        step();

        // Reset during the third PUSH of a four-result batch
        core_left[3] = 4;
        core_pay[3]  = 24'h30;
        clear_logs();
        drive_cores();
        start_batch(16'd4);
        k = 0;
        while (ack_cnt < 3 && k < 40) begin
            step();
            k++;
        end
        chk("t5_third_grant", 32'(ack_cnt), 32'd3);
        chk("t5_wren_mid", 32'(bus.dtw_fifo_wren), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_ack", 32'(bus.res_ack), 32'd0);
        chk("t5_rst_wren", 32'(bus.dtw_fifo_wren), 32'd0);
        chk("t5_rst_din", bus.dtw_fifo_din, 32'd0);
        chk("t5_rst_done", 32'(bus.done), 32'd0);
        #10 rst_n = 1'b1;
        ack_prev     = '0;
        core_left[3] = 0;
        drive_cores();
        step(); step();
        chk("t5_no_done_after_abort", 32'(done_cnt), 32'd0);
        core_left[3] = 1;
        core_pay[3]  = 24'h77;
        clear_logs();
        drive_cores();
        start_batch(16'd1);
        run_to_done(30);
        chk("t5_nwrites", 32'(wr_log.size()), 32'd1);
        chk("t5_word0", wr_log[0], 32'h03000077);
        step(); step();

        // Second start while busy is ignored
        core_left[0] = 5;
        core_pay[0]  = 24'h60;
        clear_logs();
        drive_cores();
        start_batch(16'd2);
        bus.cfg_total = 16'd9;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        run_to_done(40);
        repeat (6) step();
        chk("t6_nwrites", 32'(wr_log.size()), 32'd2);
        chk("t6_word0", wr_log[0], 32'h00000060);
        chk("t6_word1", wr_log[1], 32'h00000061);
        chk("t6_done_once", 32'(done_cnt), 32'd1);
        chk("t6_busy_idle", 32'(bus.busy), 32'd0);
        chk("t6_nacks", 32'(ack_cnt), 32'd2);
        core_left[0] = 0;
        drive_cores();
        step();

`ifdef DTW_ARB_CORE_MASK_EN
        // Masked cores 1 and 3 never win
        apply_reset();
        bus.core_enable = 4'b0101;
        for (int i = 0; i < NC; i++) begin
            core_left[i] = 2;
            core_pay[i]  = 24'hB0 + 24'(16 * i);
        end
        clear_logs();
        drive_cores();
        start_batch(16'd4);
        run_to_done(40);
        chk("tm_ngrants", 32'(grant_log.size()), 32'd4);
        chk("tm_grant0", 32'(grant_log[0]), 32'd0);
        chk("tm_grant1", 32'(grant_log[1]), 32'd2);
        chk("tm_grant2", 32'(grant_log[2]), 32'd0);
        chk("tm_grant3", 32'(grant_log[3]), 32'd2);
        for (int i = 0; i < NC; i++) core_left[i] = 0;
        drive_cores();
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dtw_result_arbiter.md
Name: dtw_result_arbiter

Overview:
- Batch controller and round-robin arbiter that shares the single result-stream FIFO write port among NUM_CORES DTW cores.
- Software-style start/total sequencing: a batch of cfg_total results is collected, each tagged with its core ID, then done is pulsed.
- Sits between the DTW core array and the dtw_fifo_wren/dtw_fifo_din/dtw_fifo_full write side of the M00 AXIS master.

Parameters:
- NUM_CORES, 4, number of requesting DTW cores (1..256).
- C_M_AXIS_TDATA_WIDTH, 32, width of the FIFO word.
- CNT_W, 16, width of cfg_total and the result counter.
- DATA_W is a localparam = C_M_AXIS_TDATA_WIDTH-8 (payload width per core).

Ports:
- M_AXIS_ACLK  in  1  clock.
- M_AXIS_ARESETN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a batch; ignored while busy.
- cfg_total  in  CNT_W  results in the batch; sampled on an accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at batch end.
- res_valid  in  NUM_CORES  per-core result request.
- res_data  in  NUM_CORES*DATA_W  flattened payloads; core i uses [i*DATA_W +: DATA_W].
- res_ack  out  NUM_CORES  one-hot, one-cycle acceptance pulse.
- dtw_fifo_wren  out  1  FIFO write strobe.
- dtw_fifo_din  out  C_M_AXIS_TDATA_WIDTH  {core_id[7:0], payload}.
- dtw_fifo_full  in  1  FIFO cannot accept a write.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; busy, done, res_ack, dtw_fifo_wren all 0; dtw_fifo_din 0; counter 0; rr_ptr 0.
- Reset mid-batch aborts the batch: no done pulse, latched word discarded.
- States: IDLE, ARB, PUSH, DONE.
- IDLE: start=1 latches cfg_total, clears the counter, sets busy.
  - Goes to DONE if cfg_total==0, otherwise to ARB.
- ARB: if no res_valid bit is set, stay in ARB.
  - Otherwise the winner is the first set bit searching upward from rr_ptr, wrapping at NUM_CORES-1 to 0.
  - Register dtw_fifo_din={winner,payload} and res_ack[winner]<=1; set rr_ptr<=winner+1, wrapping to 0; go to PUSH.
- PUSH: res_ack is high for the first PUSH cycle only.
  - dtw_fifo_wren = (state==PUSH) && !dtw_fifo_full (combinational). dtw_fifo_din holds stable while full.
  - On a write, the counter increments. If the new count == latched total, go to DONE, otherwise go to ARB.
- DONE: done=1 for one cycle, busy<=0, go to IDLE.
- Core contract: each core holds res_valid/res_data until it samples res_ack high, then drops res_valid on that same edge. The arbiter never samples a stale request because ARB follows PUSH.
- Throughput: at most one result per 2 cycles.
- Latency: request first sampled in ARB at edge N; res_ack high in cycle N+1; dtw_fifo_wren in cycle N+1 if not full.
- Simultaneous requests: strict round-robin. No core waits more than NUM_CORES grants.
- start while busy: ignored, no effect on the counter.
- Counter is unsigned CNT_W and wraps. Never exceeds total because the comparison happens on every write.
- Requests in IDLE/DONE are not acknowledged.

Optional Feature:
- Macro DTW_ARB_CORE_MASK_EN.
  - Defined: adds input core_enable[NUM_CORES]. Only res_valid & core_enable bits are eligible. Masked cores never receive res_ack. Mask is sampled every ARB cycle.
  - Undefined: port absent; all cores eligible.

Decomposition:
- Package dtw_arb_pkg: state encoding (2-bit IDLE=0, ARB=1, PUSH=2, DONE=3), ID_W=8 localparam, DATA_W derivation.
- One sub-module dtw_rr_picker: combinational round-robin priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, winner index.

Test Plan:
- Single core: NUM_CORES=4, total=3, core2 valid with payloads 0xA1,0xA2,0xA3 → FIFO words 0x020000A1..0x020000A3; done pulses once; busy falls the same cycle.
- All 4 cores continuously valid, total=8, rr_ptr=0 → grant order 0,1,2,3,0,1,2,3; each res_ack is one cycle, one-hot.
- dtw_fifo_full high for 5 cycles during PUSH → wren low; din stable; no extra res_ack; write occurs the cycle full drops.
- cfg_total=0 with start → done 2 cycles after start; no res_ack; no wren.
- Async reset asserted mid-PUSH after 2 of 4 writes → outputs 0 immediately. A new start with total=1 completes normally with counter from 0.
- start pulsed while busy (total=2, second start total=9) → batch ends after 2 writes.
  - With DTW_ARB_CORE_MASK_EN and core_enable=4'b0101 under all-valid → grants only 0,2,0,2.
